// File: rtl/pipe_sub_nbit.sv
// Pipelined N-bit unsigned subtractor: SEG result bits per stage, ripple borrow between stages,
// optional clamp-to-zero on underflow, valid/ready flow control with a global stall enable.
module pipe_sub_nbit #(
   parameter int N   = 16,
   parameter int SEG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   input  logic         sat_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] d,
   output logic         borrow,
   output logic         zero
);

   localparam int STAGES = N / SEG;

   logic                         en;
   logic [STAGES-1:0]            vld_q, brw_q, sat_q;
   logic [STAGES-1:0][N-1:0]     a_q, b_q, r_q;
   logic                         zero_q;

   logic [STAGES-1:0]            vld_n, brw_n, sat_n;
   logic [STAGES-1:0][N-1:0]     a_n, b_n, r_n;
   logic                         zero_n;

   // Index 0 is the input port, index k+1 is the register of stage k.
   logic [STAGES:0]              v_s, br_s, sat_s;
   logic [STAGES:0][N-1:0]       a_s, b_s, r_s;

   assign en        = !vld_q[STAGES-1] || out_ready;
   assign in_ready  = en;

   assign v_s   = {vld_q, in_valid};
   assign br_s  = {brw_q, bin};
   assign sat_s = {sat_q, sat_mode};
   assign a_s   = {a_q, a};
   assign b_s   = {b_q, b};
   assign r_s   = {r_q, {N{1'b0}}};

   always_comb begin
      logic [N-1:0] ra;
      logic         bw, xa, yb;
      ra     = '0;
      bw     = 1'b0;
      xa     = 1'b0;
      yb     = 1'b0;
      vld_n  = '0;
      brw_n  = '0;
      sat_n  = '0;
      a_n    = '0;
      b_n    = '0;
      r_n    = '0;
      zero_n = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         ra = r_s[k];
         bw = br_s[k];
         for (int j = 0; j < SEG; j++) begin
            xa = a_s[k][k*SEG+j];
            yb = b_s[k][k*SEG+j];
            ra[k*SEG+j] = xa ^ yb ^ bw;
            bw = (~xa & yb) | (~(xa ^ yb) & bw);
         end
         // Saturation and the zero flag are resolved in the last stage so outputs come straight from flops.
         if (k == STAGES-1) begin
            if (sat_s[k] && bw)
               ra = '0;
            zero_n = (ra == '0);
         end
         vld_n[k] = v_s[k];
         brw_n[k] = bw;
         sat_n[k] = sat_s[k];
         a_n[k]   = a_s[k];
         b_n[k]   = b_s[k];
         r_n[k]   = ra;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         brw_q  <= '0;
         sat_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         zero_q <= 1'b0;
      end else if (en) begin
         vld_q  <= vld_n;
         brw_q  <= brw_n;
         sat_q  <= sat_n;
         a_q    <= a_n;
         b_q    <= b_n;
         r_q    <= r_n;
         zero_q <= zero_n;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign d         = r_q[STAGES-1];
   assign borrow    = brw_q[STAGES-1];
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_sub_nbit.sv
// Self-checking bench for pipe_sub_nbit (N=16, SEG=4): directed cases plus a randomized run
// scored against an arithmetic reference model.
module tb_pipe_sub_nbit;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a, b;
   logic         bin, sat_mode;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] d;
   logic         borrow, zero;

   int errors  = 0;
   int checks  = 0;
   int results = 0;
   logic last_acc;
   logic [N+1:0] exp_q[$];

   pipe_sub_nbit #(.N(N), .SEG(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .sat_mode(sat_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .borrow(borrow), .zero(zero)
   );

   always #5 clk = ~clk;

   // Reference: {borrow, zero, d} from plain integer arithmetic.
   function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                          input logic mbin, input logic msat);
      logic [N-1:0] md;
      logic         mbr;
      mbr = (int'(ma) < int'(mb) + int'(mbin));
      md  = N'(int'(ma) - int'(mb) - int'(mbin));
      if (msat && mbr) md = '0;
      return {mbr, (md == 0), md};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score any handshaked result, record any accepted input, then advance.
   task automatic cycle();
      logic [N+1:0] e;
      #1;
      last_acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         results++;
         check("result_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("d", 32'(d), 32'(e[N-1:0]));
            check("borrow", 32'(borrow), 32'(e[N+1]));
            check("zero", 32'(zero), 32'(e[N]));
         end
      end
      if (last_acc)
         exp_q.push_back(model(a, b, bin, sat_mode));
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                                input logic tbin, input logic tsat,
                                input logic [N-1:0] ed, input logic eb, input logic ez);
      int lat;
      a = ta; b = tb; bin = tbin; sat_mode = tsat;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      cycle();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         cycle();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
      check({tag, "_d"}, 32'(d), 32'(ed));
      check({tag, "_borrow"}, 32'(borrow), 32'(eb));
      check({tag, "_zero"}, 32'(zero), 32'(ez));
      cycle();
   endtask

   initial begin
      logic [N-1:0] d_s;
      logic         b_s;
      int i, cyc, res0, n_acc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; bin = 1'b0; sat_mode = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_d", 32'(d), 0);
      check("rst_borrow", 32'(borrow), 0);
      check("rst_zero", 32'(zero), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      rst_n = 1'b1;

      applyStimulus("basic",      16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
      applyStimulus("uflow_wrap", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      applyStimulus("uflow_sat",  16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
      applyStimulus("bin_one",    16'h0005, 16'h0005, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      applyStimulus("bin_zero",   16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      applyStimulus("ripple",     16'h1000, 16'h0001, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);

      // Back-to-back stream with a 3-cycle downstream stall while the output is occupied.
      i = 0; cyc = 0; res0 = results; d_s = '0; b_s = 1'b0;
      while ((i < 8 || exp_q.size() > 0) && cyc < 50) begin
         out_ready = !(cyc >= 5 && cyc <= 7);
         if (i < 8) begin
            in_valid = 1'b1; a = N'(i + 'h100); b = N'(i); bin = 1'b0; sat_mode = 1'b0;
         end else
            in_valid = 1'b0;
         #1;
         if (cyc == 5) begin
            d_s = d; b_s = borrow;
         end
         if (cyc >= 5 && cyc <= 7) begin
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_d_stable", 32'(d), 32'(d_s));
            check("stall_borrow_stable", 32'(borrow), 32'(b_s));
         end
         cycle();
         if (last_acc) i++;
         cyc++;
      end
      check("stall_accepted", 32'(i), 8);
      check("stall_results", 32'(results - res0), 8);
      in_valid = 1'b0; out_ready = 1'b1;

      // Reset with three transactions in flight.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; a = N'('h5000 + k); b = N'(k); bin = 1'b0; sat_mode = 1'b0;
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      check("pre_reset_out_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_d", 32'(d), 0);
      check("midrst_borrow", 32'(borrow), 0);
      check("midrst_zero", 32'(zero), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("no_stale_result", 32'(out_valid), 0);
      end
      applyStimulus("post_reset", 16'hABCD, 16'h0BCD, 1'b0, 1'b0, 16'hA000, 1'b0, 1'b0);

      // Randomized traffic with random backpressure.
      n_acc = 0; cyc = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = N'($urandom);
         b = ($urandom_range(0, 7) == 0) ? a : N'($urandom);
         bin = 1'($urandom);
         sat_mode = 1'($urandom);
         cycle();
         if (last_acc) n_acc++;
         cyc++;
      end
      check("random_accepted", 32'(n_acc), 10000);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++)
         cycle();
      check("drain_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
